// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pipe_pkg;

    typedef enum logic [2:0] {
        RUN,
        MEM_WAIT,
        DRAIN,
        HALTED,
        ERROR
    } hz_state_t;

    // Number of non-stalled cycles needed to empty EX, MEM and WB.
    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic pcWrite;
        logic ifidWrite;
        logic idexWrite;
        logic exmemWrite;
        logic ifidFlush;
        logic idexFlush;
        logic memwbBubble;
    } pipe_ctl_t;

    // Every stage advances and nothing is flushed.
    function automatic pipe_ctl_t ctlDefault();
        pipe_ctl_t c;
        c.pcWrite     = 1'b1;
        c.ifidWrite   = 1'b1;
        c.idexWrite   = 1'b1;
        c.exmemWrite  = 1'b1;
        c.ifidFlush   = 1'b0;
        c.idexFlush   = 1'b0;
        c.memwbBubble = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline:
// load-use stalls, branch flushes, memory freezes with timeout and
// a debug halt/drain sequence, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic [4:0]       exRt,
    input  logic             exMemRead,
    input  logic             exBranchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             haltReq,
    input  logic             cntClr,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             ifidFlush,
    output logic             idexFlush,
    output logic             memwbBubble,
    output logic             haltAck,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCycles,
    output logic [CNT_W-1:0] flushCount
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    hz_state_t          state, nextState;
    logic [WAIT_W-1:0]  waitCnt, nextWaitCnt;
    logic [DRAIN_W-1:0] drainCnt, nextDrainCnt;
    pipe_ctl_t          ctl;
    logic               memStall;
    logic               loadUse;
    logic               branchTake;

    assign memStall = memReq & ~memReady;
    assign loadUse  = exMemRead & (exRt != 5'd0) &
                      ((exRt == idRs) | (idUsesRt & (exRt == idRt)));

    // State, memory wait count and drain count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            waitCnt  <= '0;
            drainCnt <= '0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWaitCnt;
            drainCnt <= nextDrainCnt;
        end
    end

    // Next state and pipeline controls; the cycle in which memory finally
    // answers in MEM_WAIT is an ordinary running cycle, so branches, halts
    // and load-use hazards are serviced there too rather than lost. A
    // halt freezes the front end already in its accepting cycle so the ID
    // instruction is never issued with a stale operand.
    always_comb begin
        ctl          = ctlDefault();
        nextState    = state;
        nextWaitCnt  = waitCnt;
        nextDrainCnt = drainCnt;
        haltAck      = 1'b0;
        memTimeout   = 1'b0;
        branchTake   = 1'b0;
        if (state == ERROR) begin
            ctl.pcWrite     = 1'b0;
            ctl.ifidWrite   = 1'b0;
            ctl.idexWrite   = 1'b0;
            ctl.exmemWrite  = 1'b0;
            ctl.idexFlush   = 1'b1;
            ctl.memwbBubble = 1'b1;
            memTimeout      = 1'b1;
        end else if (memStall) begin
            ctl.pcWrite     = 1'b0;
            ctl.ifidWrite   = 1'b0;
            ctl.idexWrite   = 1'b0;
            ctl.exmemWrite  = 1'b0;
            ctl.memwbBubble = 1'b1;
            case (state)
                RUN: begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = WAIT_W'(1);
                end
                MEM_WAIT: begin
                    nextWaitCnt = waitCnt + 1'b1;
                    if (waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        nextState = ERROR;
                    end
                end
                HALTED:  haltAck = 1'b1;
                default: ;
            endcase
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    nextState   = RUN;
                    nextWaitCnt = '0;
                    if (exBranchTaken) begin
                        ctl.ifidFlush = 1'b1;
                        ctl.idexFlush = 1'b1;
                        branchTake    = 1'b1;
                    end else if (haltReq) begin
                        ctl.pcWrite   = 1'b0;
                        ctl.ifidWrite = 1'b0;
                        ctl.idexFlush = 1'b1;
                        nextState     = DRAIN;
                        nextDrainCnt  = DRAIN_W'(DRAIN_CYCLES);
                    end else if (loadUse) begin
                        ctl.pcWrite   = 1'b0;
                        ctl.ifidWrite = 1'b0;
                        ctl.idexFlush = 1'b1;
                    end
                end
                DRAIN: begin
                    ctl.pcWrite   = 1'b0;
                    ctl.ifidWrite = 1'b0;
                    ctl.idexFlush = 1'b1;
                    if (drainCnt <= DRAIN_W'(1)) begin
                        nextState    = HALTED;
                        nextDrainCnt = '0;
                    end else begin
                        nextDrainCnt = drainCnt - 1'b1;
                    end
                end
                HALTED: begin
                    ctl.pcWrite   = 1'b0;
                    ctl.ifidWrite = 1'b0;
                    ctl.idexFlush = 1'b1;
                    haltAck       = 1'b1;
                    if (!haltReq) begin
                        nextState = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pcWrite     = ctl.pcWrite;
    assign ifidWrite   = ctl.ifidWrite;
    assign idexWrite   = ctl.idexWrite;
    assign exmemWrite  = ctl.exmemWrite;
    assign ifidFlush   = ctl.ifidFlush;
    assign idexFlush   = ctl.idexFlush;
    assign memwbBubble = ctl.memwbBubble;

    sat_counter #(.WIDTH(CNT_W)) stallCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (~ctl.pcWrite),
        .clr   (cntClr),
        .count (stallCycles)
    );

    sat_counter #(.WIDTH(CNT_W)) flushCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (branchTake),
        .clr   (cntClr),
        .count (flushCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: combinational vector table
// plus hand-written multi-cycle sequences on a default and a small instance.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] idRs, idRt, exRt;
    logic idUsesRt, exMemRead, exBranchTaken, memReq, memReady, haltReq, cntClr;

    logic pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush;
    logic memwbBubble, haltAck, memTimeout;
    logic [15:0] stallCycles, flushCount;

    logic sPcWrite, sIfidWrite, sIdexWrite, sExmemWrite, sIfidFlush, sIdexFlush;
    logic sMemwbBubble, sHaltAck, sMemTimeout;
    logic [3:0] sStallCycles, sFlushCount;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exRt(exRt), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken),
        .memReq(memReq), .memReady(memReady), .haltReq(haltReq), .cntClr(cntClr),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
        .exmemWrite(exmemWrite), .ifidFlush(ifidFlush), .idexFlush(idexFlush),
        .memwbBubble(memwbBubble), .haltAck(haltAck), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .exRt(exRt), .exMemRead(exMemRead), .exBranchTaken(exBranchTaken),
        .memReq(memReq), .memReady(memReady), .haltReq(haltReq), .cntClr(cntClr),
        .pcWrite(sPcWrite), .ifidWrite(sIfidWrite), .idexWrite(sIdexWrite),
        .exmemWrite(sExmemWrite), .ifidFlush(sIfidFlush), .idexFlush(sIdexFlush),
        .memwbBubble(sMemwbBubble), .haltAck(sHaltAck), .memTimeout(sMemTimeout),
        .stallCycles(sStallCycles), .flushCount(sFlushCount)
    );

    // {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush, memwbBubble, haltAck, memTimeout}
    logic [8:0] ctlVec, sCtlVec;
    assign ctlVec  = {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexFlush,
                      memwbBubble, haltAck, memTimeout};
    assign sCtlVec = {sPcWrite, sIfidWrite, sIdexWrite, sExmemWrite, sIfidFlush, sIdexFlush,
                      sMemwbBubble, sHaltAck, sMemTimeout};

    typedef struct {
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic       idUsesRt;
        logic [4:0] exRt;
        logic       exMemRead;
        logic       exBranchTaken;
        logic       memReq;
        logic       memReady;
        logic [8:0] expCtl;
    } vector_t;

    vector_t vecs[10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        idRs = 0; idRt = 0; exRt = 0; idUsesRt = 0; exMemRead = 0; exBranchTaken = 0;
        memReq = 0; memReady = 0; haltReq = 0; cntClr = 0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vector_t v);
        idRs = v.idRs; idRt = v.idRt; idUsesRt = v.idUsesRt; exRt = v.exRt;
        exMemRead = v.exMemRead; exBranchTaken = v.exBranchTaken;
        memReq = v.memReq; memReady = v.memReady;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Halt from RUN; optional memory stall for stallLen cycles after edge stallAfter.
    task automatic runHalt(input int stallAfter, input int stallLen, output int ackEdge);
        applyReset();
        haltReq = 1'b1;
        ackEdge = 0;
        for (int e = 1; e <= 10; e++) begin
            stepEdge();
            if (haltAck && ackEdge == 0) ackEdge = e;
            if (stallLen > 0 && e == stallAfter) begin
                memReq = 1'b1;
                memReady = 1'b0;
            end
            if (stallLen > 0 && e == stallAfter + stallLen) memReq = 1'b0;
        end
    endtask

    initial begin
        int bad;
        int ackEdge;
        rst = 1'b1;
        clearInputs();

        //                 idRs idRt use exRt mr  br  req rdy  expected
        vecs[0] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1111000_00};
        vecs[1] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0011010_00};
        vecs[2] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b1111000_00};
        vecs[3] = '{5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 9'b1111000_00};
        vecs[4] = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0011010_00};
        vecs[5] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'b1111000_00};
        vecs[6] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 9'b1111110_00};
        vecs[7] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 9'b0000001_00};
        vecs[8] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 9'b0011010_00};
        vecs[9] = '{5'd9, 5'd9, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 9'b1111000_00};

        // Reset state.
        applyReset();
        #1;
        checkOutput("reset ctl", 32'(ctlVec), 32'(9'b1111000_00));
        checkOutput("reset stallCycles", 32'(stallCycles), 0);
        checkOutput("reset flushCount", 32'(flushCount), 0);

        // Combinational vector table, each from a freshly reset RUN state.
        foreach (vecs[i]) begin
            applyReset();
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vector %0d ctl", i), 32'(ctlVec), 32'(vecs[i].expCtl));
        end

        // Load-use stalls exactly one cycle, then ID/EX holds a bubble.
        applyReset();
        exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
        #1;
        checkOutput("loaduse pcWrite", 32'(pcWrite), 0);
        stepEdge();
        exMemRead = 1'b0;
        #1;
        checkOutput("loaduse release ctl", 32'(ctlVec), 32'(9'b1111000_00));
        checkOutput("loaduse stallCycles", 32'(stallCycles), 1);
        stepEdge();
        checkOutput("loaduse stallCycles hold", 32'(stallCycles), 1);

        // Branch beats load-use and counts one flush.
        applyReset();
        exBranchTaken = 1'b1; exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5;
        stepEdge();
        exBranchTaken = 1'b0; exMemRead = 1'b0;
        checkOutput("branch flushCount", 32'(flushCount), 1);
        checkOutput("branch stallCycles", 32'(stallCycles), 0);

        // Ten-cycle memory freeze on the default instance.
        applyReset();
        memReq = 1'b1; memReady = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ctlVec !== 9'b0000001_00) bad++;
            @(posedge clk);
        end
        #1;
        checkOutput("memfreeze bad cycles", 32'(bad), 0);
        memReady = 1'b1;
        #1;
        checkOutput("memfreeze release ctl", 32'(ctlVec), 32'(9'b1111000_00));
        stepEdge();
        memReq = 1'b0;
        #1;
        checkOutput("memfreeze stallCycles", 32'(stallCycles), 10);
        checkOutput("memfreeze no timeout", 32'(memTimeout), 0);

        // Wait count clears when memory answers (small instance, timeout 4).
        applyReset();
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 3; i++) stepEdge();
        memReady = 1'b1;
        stepEdge();
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) stepEdge();
        checkOutput("waitcnt clear no timeout", 32'(sMemTimeout), 0);

        // Timeout after four not-ready cycles, sticky, counter saturation.
        applyReset();
        memReq = 1'b1; memReady = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            stepEdge();
            if (e == 3) checkOutput("timeout not yet", 32'(sMemTimeout), 0);
            if (e == 4) checkOutput("timeout asserted", 32'(sMemTimeout), 1);
        end
        memReq = 1'b0;
        #1;
        checkOutput("error ctl sticky", 32'(sCtlVec), 32'(9'b0000011_01));
        for (int i = 0; i < 20; i++) stepEdge();
        checkOutput("saturated stallCycles", 32'(sStallCycles), 15);
        cntClr = 1'b1;
        stepEdge();
        cntClr = 1'b0;
        checkOutput("cntClr zeroes", 32'(sStallCycles), 0);
        stepEdge();
        checkOutput("count after clr", 32'(sStallCycles), 1);
        applyReset();
        #1;
        checkOutput("reset clears timeout", 32'(sMemTimeout), 0);
        checkOutput("reset clears stall small", 32'(sStallCycles), 0);

        // Halt with no stalls: ack after 4 edges.
        runHalt(0, 0, ackEdge);
        checkOutput("halt ack edge", 32'(ackEdge), 4);

        // Halt with a 2-cycle memory stall during DRAIN: ack after 6 edges.
        applyReset();
        haltReq = 1'b1;
        ackEdge = 0;
        for (int e = 1; e <= 8; e++) begin
            stepEdge();
            if (e == 2) begin
                checkOutput("drain ctl", 32'(ctlVec), 32'(9'b0011010_00));
                memReq = 1'b1;
                memReady = 1'b0;
            end
            if (e == 4) memReq = 1'b0;
            if (haltAck && ackEdge == 0) ackEdge = e;
        end
        checkOutput("halt stall ack edge", 32'(ackEdge), 6);
        checkOutput("halted ctl", 32'(ctlVec), 32'(9'b0011010_10));
        haltReq = 1'b0;
        #1;
        checkOutput("halted ack holds", 32'(haltAck), 1);
        stepEdge();
        checkOutput("resume ctl", 32'(ctlVec), 32'(9'b1111000_00));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
